// File: rtl/snk_byte_serializer_pkg.sv
// Shared sink-side configuration for the byte serializer.
// SEQ state exists only when SNK_BYTE_SERIALIZER_SEQ_EN is defined.
package sink_config;

  localparam int SNK_WIDTH     = 12;
  localparam int BYTE_WIDTH    = 8;
  localparam int SNK_NUM_BYTES = (SNK_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;

`ifdef SNK_BYTE_SERIALIZER_SEQ_EN
  typedef enum logic [1:0] {IDLE, SEQ, SEND} ser_state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} ser_state_t;
`endif

endpackage

// File: rtl/snk_byte_serializer.sv
// Serializes one sink word into MSB-first byte beats; one word buffered, zero-bubble reload.
// Optional macro SNK_BYTE_SERIALIZER_SEQ_EN prefixes each word with an 8-bit sequence beat.
module snk_byte_serializer
  import sink_config::*;
#(
  parameter int SNK_WIDTH  = sink_config::SNK_WIDTH,
  parameter int BYTE_WIDTH = sink_config::BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic [SNK_WIDTH-1:0]  snk,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  busy
);

  localparam int NUM_BYTES = (SNK_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
  localparam int SRW       = NUM_BYTES * BYTE_WIDTH;
  localparam int IDXW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  ser_state_t      state;
  logic [IDXW-1:0] byte_idx;
  logic [SRW-1:0]  sr;
  logic            last_beat;

  // The only state that re-enters after a load depends on whether sequence beats exist.
`ifdef SNK_BYTE_SERIALIZER_SEQ_EN
  localparam ser_state_t LOAD_STATE = SEQ;
  logic [7:0] seq_cnt;
`else
  localparam ser_state_t LOAD_STATE = SEND;
`endif

  assign last_beat = (state == SEND) && (byte_idx == LAST_IDX);
  assign snk_ready = (state == IDLE) || (last_beat && tx_ready);
  assign busy      = tx_valid;

`ifdef SNK_BYTE_SERIALIZER_SEQ_EN
  assign tx_data = (state == SEQ) ? BYTE_WIDTH'(seq_cnt) : sr[SRW-1 -: BYTE_WIDTH];
`else
  assign tx_data = sr[SRW-1 -: BYTE_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      sr       <= '0;
      tx_valid <= 1'b0;
`ifdef SNK_BYTE_SERIALIZER_SEQ_EN
      seq_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (snk_valid) begin
            sr       <= SRW'(snk);
            byte_idx <= '0;
            tx_valid <= 1'b1;
            state    <= LOAD_STATE;
          end
        end
`ifdef SNK_BYTE_SERIALIZER_SEQ_EN
        SEQ: begin
          if (tx_ready) begin
            seq_cnt <= seq_cnt + 8'd1;
            state   <= SEND;
          end
        end
`endif
        SEND: begin
          if (tx_ready) begin
            if (byte_idx != LAST_IDX) begin
              sr       <= sr << BYTE_WIDTH;
              byte_idx <= byte_idx + IDXW'(1);
            end else if (snk_valid) begin
              // Reload on the final handshake keeps the output stream gap-free.
              sr       <= SRW'(snk);
              byte_idx <= '0;
              state    <= LOAD_STATE;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
